// File: rtl/mod_mul_serial_pkg.sv
// Shared definitions for the ECC modular-arithmetic datapath: default width,
// FSM state codes and the P-256 field prime.
package mod_mul_serial_pkg;

  localparam int DEFAULT_WIDTH = 256;

  // State codes kept as plain constants so older RTL can compare against them directly.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [255:0] P256_PRIME =
    256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;

endpackage

// File: rtl/mod_mul_serial_mod_add_step.sv
// Combinational (x + y) mod m for x, y < m; the raw sum is below 2m, so one
// conditional subtract is enough.
module mod_add_step #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH:0] rawSum;
  logic           needSub;

  assign rawSum  = {1'b0, x} + {1'b0, y};
  assign needSub = (rawSum >= {1'b0, m});

  // The carry bit is only needed for the compare; modulo-2^WIDTH wrap makes the
  // low bits of x + y - m correct even when the sum overflowed WIDTH bits.
  assign sum = needSub ? (x + y - m) : (x + y);

endmodule

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: out_data = (opA * opB) mod opM,
// one multiplier bit per clock, MSB first, with a start/busy/done handshake.
module mod_mul_serial
  import mod_mul_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [WIDTH-1:0] opM,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] out_data
);

  logic [0:0]       state;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [WIDTH-1:0] regM;
  logic [WIDTH-1:0] accR;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] dblR;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] nextR;

  // Double-and-add-mod: R' = (2R mod M + b*A) mod M.
  assign addend = regB[cnt] ? regA : '0;

  mod_add_step #(.WIDTH(WIDTH)) u_double (
    .x   (accR),
    .y   (accR),
    .m   (regM),
    .sum (dblR)
  );

  mod_add_step #(.WIDTH(WIDTH)) u_add (
    .x   (dblR),
    .y   (addend),
    .m   (regM),
    .sum (nextR)
  );

  // NOTE: every register here updates with <= so all of them sample the same
  // pre-edge values; the wide data registers are reset too, because an aborted
  // operation must leave nothing behind for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      regA     <= '0;
      regB     <= '0;
      regM     <= '0;
      accR     <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      out_data <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            regA <= opA;
            regB <= opB;
            regM <= opM;
            if (opM == '0) begin
              // A zero modulus has no valid result: report it without running.
              done     <= 1'b1;
              err      <= 1'b1;
              out_data <= '0;
            end else begin
              accR  <= '0;
              cnt   <= CNT_W'(WIDTH - 1);
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          accR <= nextR;
          if (cnt == '0) begin
            out_data <= nextR;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
